// File: rtl/alu_issue_pkg.sv
// Purpose: shared constants and types for the ALU issue unit.
//   - ALU opcode encodings, funct3 values, FSM state encoding.
//   - decode_t: payload produced by the funct3/funct7 decoder.
package alu_issue_pkg;

  localparam int unsigned OPCODE_W = 3;
  localparam int unsigned FUNCT3_W = 3;
  localparam int unsigned STATE_W  = 2;
  localparam int unsigned STAT_W   = 32;
  localparam int unsigned SHAMT_W  = 5;

  // ALU opcodes
  localparam logic [OPCODE_W-1:0] ALU_ADD  = 3'b000;
  localparam logic [OPCODE_W-1:0] ALU_SUB  = 3'b001;
  localparam logic [OPCODE_W-1:0] ALU_OR   = 3'b010;
  localparam logic [OPCODE_W-1:0] ALU_AND  = 3'b011;
  localparam logic [OPCODE_W-1:0] ALU_SLL  = 3'b100;
  localparam logic [OPCODE_W-1:0] ALU_SRL  = 3'b101;
  localparam logic [OPCODE_W-1:0] ALU_XOR  = 3'b110;
  localparam logic [OPCODE_W-1:0] ALU_SLTU = 3'b111;

  // RISC-V funct3 values for integer ops
  localparam logic [FUNCT3_W-1:0] F3_ADD  = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_SLL  = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_SLT  = 3'b010;
  localparam logic [FUNCT3_W-1:0] F3_SLTU = 3'b011;
  localparam logic [FUNCT3_W-1:0] F3_XOR  = 3'b100;
  localparam logic [FUNCT3_W-1:0] F3_SRL  = 3'b101;
  localparam logic [FUNCT3_W-1:0] F3_OR   = 3'b110;
  localparam logic [FUNCT3_W-1:0] F3_AND  = 3'b111;

  // FSM states
  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_EXEC = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic                illegal;
    logic                is_shift;
  } decode_t;

endpackage

// File: rtl/alu_op_decode.sv
// Purpose: combinational funct3/funct7_5/is_imm -> ALU opcode decoder.
// Ports:
//   funct3, funct7_5, is_imm : decoded instruction fields
//   dec_c                    : {opcode, illegal, is_shift}
module alu_op_decode
  import alu_issue_pkg::*;
(
  input  logic [FUNCT3_W-1:0] funct3,
  input  logic                funct7_5,
  input  logic                is_imm,
  output decode_t             dec_c
);

  always_comb begin
    dec_c.opcode   = ALU_ADD;
    dec_c.illegal  = 1'b0;
    dec_c.is_shift = 1'b0;
    case (funct3)
      // ADDI ignores funct7_5 because that bit is immediate payload
      F3_ADD:  dec_c.opcode = (!is_imm && funct7_5) ? ALU_SUB : ALU_ADD;
      F3_SLL: begin
        dec_c.opcode   = ALU_SLL;
        dec_c.is_shift = 1'b1;
      end
      F3_SRL: begin
        dec_c.opcode   = ALU_SRL;
        dec_c.is_shift = 1'b1;
        // arithmetic shifts are not supported by this ALU
        dec_c.illegal  = funct7_5;
      end
      F3_XOR:  dec_c.opcode = ALU_XOR;
      F3_OR:   dec_c.opcode = ALU_OR;
      F3_AND:  dec_c.opcode = ALU_AND;
      F3_SLTU: dec_c.opcode = ALU_SLTU;
      // signed compare is not supported by this ALU
      F3_SLT:  dec_c.illegal = 1'b1;
      default: dec_c.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_unit.sv
// Purpose: issues decoded R/I-type integer instructions to a combinational
//   3-bit-opcode ALU and holds the result for writeback.
// Ports:
//   clk, rst_n                       : clock, async active-low reset
//   in_valid/in_ready + in_*         : instruction input handshake
//   alu_opcode, alu_a, alu_b         : registered ALU operands
//   alu_result, alu_zero             : ALU outputs
//   out_valid/out_ready + out_*      : writeback handshake
// Optional: define ALU_ISSUE_STATS_EN to add stat_issued/stat_illegal counters.
module alu_issue_unit
  import alu_issue_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
)
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FUNCT3_W-1:0]   in_funct3,
  input  logic                  in_funct7_5,
  input  logic                  in_is_imm,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [XLEN-1:0]       in_rs1_data,
  input  logic [XLEN-1:0]       in_rs2_data,
  input  logic [XLEN-1:0]       in_imm,
  output logic [OPCODE_W-1:0]   alu_opcode,
  output logic [XLEN-1:0]       alu_a,
  output logic [XLEN-1:0]       alu_b,
  input  logic [XLEN-1:0]       alu_result,
  input  logic                  alu_zero,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [XLEN-1:0]       out_result,
  output logic                  out_zero,
  output logic                  out_illegal
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [STAT_W-1:0]     stat_issued,
  output logic [STAT_W-1:0]     stat_illegal
`endif
);

  logic [STATE_W-1:0]    state, state_d;
  decode_t               dec;
  logic [XLEN-1:0]       b_sel, b_eff;
  logic [OPCODE_W-1:0]   opcode_d;
  logic [XLEN-1:0]       a_d, b_d, result_d;
  logic [REG_ADDR_W-1:0] rd_d;
  logic                  zero_d, illegal_d;

  alu_op_decode u_decode (
    .funct3   (in_funct3),
    .funct7_5 (in_funct7_5),
    .is_imm   (in_is_imm),
    .dec_c    (dec)
  );

  // Shift amounts are truncated here so the ALU never sees >= XLEN
  assign b_sel = in_is_imm ? in_imm : in_rs2_data;
  assign b_eff = dec.is_shift ? XLEN'(b_sel[SHAMT_W-1:0]) : b_sel;

  // Next-state and next output-register values
  always_comb begin
    state_d   = state;
    opcode_d  = alu_opcode;
    a_d       = alu_a;
    b_d       = alu_b;
    rd_d      = out_rd;
    result_d  = out_result;
    zero_d    = out_zero;
    illegal_d = out_illegal;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          opcode_d = dec.opcode;
          a_d      = in_rs1_data;
          b_d      = b_eff;
          rd_d     = in_rd;
          if (dec.illegal) begin
            // no ALU pass needed: report a zero result straight away
            state_d   = ST_DONE;
            illegal_d = 1'b1;
            result_d  = '0;
            zero_d    = 1'b0;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        result_d  = alu_result;
        zero_d    = alu_zero;
        illegal_d = 1'b0;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; handshake flags follow the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      alu_opcode  <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      out_rd      <= '0;
      out_result  <= '0;
      out_zero    <= 1'b0;
      out_illegal <= 1'b0;
    end else begin
      state       <= state_d;
      in_ready    <= (state_d == ST_IDLE);
      out_valid   <= (state_d == ST_DONE);
      alu_opcode  <= opcode_d;
      alu_a       <= a_d;
      alu_b       <= b_d;
      out_rd      <= rd_d;
      out_result  <= result_d;
      out_zero    <= zero_d;
      out_illegal <= illegal_d;
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  // Accept/illegal counters, wrapping naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued  <= '0;
      stat_illegal <= '0;
    end else if ((state == ST_IDLE) && in_valid) begin
      stat_issued <= stat_issued + STAT_W'(1);
      if (dec.illegal) begin
        stat_illegal <= stat_illegal + STAT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit: directed vector table, hand-written
// backpressure/reset sequences, and randomized ops against a reference model.
module tb_alu_issue_unit;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid, in_ready;
  logic [2:0]      in_funct3;
  logic            in_funct7_5, in_is_imm;
  logic [RW-1:0]   in_rd;
  logic [XLEN-1:0] in_rs1_data, in_rs2_data, in_imm;
  logic [2:0]      alu_opcode;
  logic [XLEN-1:0] alu_a, alu_b, alu_result;
  logic            alu_zero;
  logic            out_valid, out_ready;
  logic [RW-1:0]   out_rd;
  logic [XLEN-1:0] out_result;
  logic            out_zero, out_illegal;
`ifdef ALU_ISSUE_STATS_EN
  logic [31:0]     stat_issued, stat_illegal;
`endif

  int checks   = 0;
  int failures = 0;
  int exp_issued  = 0;
  int exp_illegal = 0;

  always #5 clk = ~clk;

  alu_issue_unit #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_funct3   (in_funct3),
    .in_funct7_5 (in_funct7_5),
    .in_is_imm   (in_is_imm),
    .in_rd       (in_rd),
    .in_rs1_data (in_rs1_data),
    .in_rs2_data (in_rs2_data),
    .in_imm      (in_imm),
    .alu_opcode  (alu_opcode),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_rd      (out_rd),
    .out_result  (out_result),
    .out_zero    (out_zero),
    .out_illegal (out_illegal)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .stat_issued  (stat_issued),
    .stat_illegal (stat_illegal)
`endif
  );

  // Behavioural ALU: full-width shift so an untruncated operand shows up
  always_comb begin
    case (alu_opcode)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a | alu_b;
      3'b011:  alu_result = alu_a & alu_b;
      3'b100:  alu_result = alu_a << alu_b;
      3'b101:  alu_result = alu_a >> alu_b;
      3'b110:  alu_result = alu_a ^ alu_b;
      default: alu_result = (alu_a < alu_b) ? 32'd1 : 32'd0;
    endcase
  end
  assign alu_zero = (alu_result == 32'd0);

  typedef struct {
    logic [2:0]  f3;
    logic        f7;
    logic        is_imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [2:0]  exp_op;
    logic [31:0] exp_b;
    logic        exp_ill;
    logic [31:0] exp_res;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Reference model from the instruction semantics
  function automatic vec_t ref_model(input logic [2:0] f3, input logic f7, input logic is_imm,
                                     input logic [31:0] rs1, input logic [31:0] rs2,
                                     input logic [31:0] imm);
    vec_t v;
    logic [31:0] b;
    b = is_imm ? imm : rs2;
    v.f3 = f3; v.f7 = f7; v.is_imm = is_imm; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
    v.exp_ill = 1'b0;
    v.exp_b   = b;
    v.exp_op  = 3'b000;
    v.exp_res = 32'd0;
    case (f3)
      3'd0: if (!is_imm && f7) begin v.exp_op = 3'b001; v.exp_res = rs1 - b; end
            else begin v.exp_op = 3'b000; v.exp_res = rs1 + b; end
      3'd1: begin v.exp_op = 3'b100; v.exp_b = {27'd0, b[4:0]}; v.exp_res = rs1 << b[4:0]; end
      3'd5: if (f7) v.exp_ill = 1'b1;
            else begin v.exp_op = 3'b101; v.exp_b = {27'd0, b[4:0]}; v.exp_res = rs1 >> b[4:0]; end
      3'd4: begin v.exp_op = 3'b110; v.exp_res = rs1 ^ b; end
      3'd6: begin v.exp_op = 3'b010; v.exp_res = rs1 | b; end
      3'd7: begin v.exp_op = 3'b011; v.exp_res = rs1 & b; end
      3'd3: begin v.exp_op = 3'b111; v.exp_res = (rs1 < b) ? 32'd1 : 32'd0; end
      default: v.exp_ill = 1'b1;
    endcase
    if (v.exp_ill) v.exp_res = 32'd0;
    v.exp_zero = !v.exp_ill && (v.exp_res == 32'd0);
    return v;
  endfunction

  task automatic drive_in(input vec_t v, input logic [RW-1:0] rd);
    in_valid    = 1'b1;
    in_funct3   = v.f3;
    in_funct7_5 = v.f7;
    in_is_imm   = v.is_imm;
    in_rs1_data = v.rs1;
    in_rs2_data = v.rs2;
    in_imm      = v.imm;
    in_rd       = rd;
  endtask

  task automatic scramble_in();
    in_valid    = 1'b0;
    in_funct3   = 3'($urandom);
    in_funct7_5 = 1'($urandom);
    in_is_imm   = 1'($urandom);
    in_rs1_data = $urandom;
    in_rs2_data = $urandom;
    in_imm      = $urandom;
  endtask

  task automatic chk_stats(input string tag);
`ifdef ALU_ISSUE_STATS_EN
    chk({tag, " stat_issued"}, stat_issued, 32'(exp_issued));
    chk({tag, " stat_illegal"}, stat_illegal, 32'(exp_illegal));
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // One full transaction; called at posedge+1 with the unit idle
  task automatic do_op(input vec_t v, input logic [RW-1:0] rd, input int rdy_dly, input string tag);
    int lat;
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    drive_in(v, rd);
    @(posedge clk); #1;
    scramble_in();
    exp_issued++;
    if (v.exp_ill) exp_illegal++;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), v.exp_ill ? 32'd1 : 32'd2);
    chk({tag, " alu_a"}, alu_a, v.rs1);
    if (!v.exp_ill) begin
      chk({tag, " alu_opcode"}, 32'(alu_opcode), 32'(v.exp_op));
      chk({tag, " alu_b"}, alu_b, v.exp_b);
    end
    chk({tag, " out_result"}, out_result, v.exp_res);
    chk({tag, " out_zero"}, 32'(out_zero), 32'(v.exp_zero));
    chk({tag, " out_illegal"}, 32'(out_illegal), 32'(v.exp_ill));
    chk({tag, " out_rd"}, 32'(out_rd), 32'(rd));
    chk_stats(tag);
    for (int i = 0; i < rdy_dly; i++) begin
      @(posedge clk); #1;
      chk({tag, " out_valid held"}, 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
    chk({tag, " in_ready back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b0;
    out_ready = 1'b0;
    scramble_in();
    in_rd = '0;

    // Directed vectors: {f3, f7, is_imm, rs1, rs2, imm, op, b, ill, result, zero}
    vecs[0]  = '{3'd0, 1'b0, 1'b0, 32'd5, 32'd7, 32'd99, 3'b000, 32'd7, 1'b0, 32'd12, 1'b0};
    vecs[1]  = '{3'd0, 1'b1, 1'b0, 32'h1234, 32'h1234, 32'd0, 3'b001, 32'h1234, 1'b0, 32'd0, 1'b1};
    vecs[2]  = '{3'd0, 1'b1, 1'b1, 32'd3, 32'd9, 32'hFFFF_FFFF, 3'b000, 32'hFFFF_FFFF, 1'b0, 32'd2, 1'b0};
    vecs[3]  = '{3'd1, 1'b0, 1'b1, 32'd1, 32'd0, 32'h0000_0421, 3'b100, 32'd1, 1'b0, 32'd2, 1'b0};
    vecs[4]  = '{3'd2, 1'b0, 1'b0, 32'd1, 32'd2, 32'd0, 3'b000, 32'd0, 1'b1, 32'd0, 1'b0};
    vecs[5]  = '{3'd5, 1'b1, 1'b0, 32'h8000_0000, 32'd1, 32'd0, 3'b000, 32'd0, 1'b1, 32'd0, 1'b0};
    vecs[6]  = '{3'd5, 1'b0, 1'b0, 32'h8000_0000, 32'd35, 32'd0, 3'b101, 32'd3, 1'b0, 32'h1000_0000, 1'b0};
    vecs[7]  = '{3'd4, 1'b0, 1'b1, 32'hFF00_FF00, 32'd0, 32'h0F0F_0F0F, 3'b110, 32'h0F0F_0F0F, 1'b0, 32'hF00F_F00F, 1'b0};
    vecs[8]  = '{3'd6, 1'b0, 1'b0, 32'h0000_00F0, 32'h0000_0F00, 32'd0, 3'b010, 32'h0000_0F00, 1'b0, 32'h0000_0FF0, 1'b0};
    vecs[9]  = '{3'd7, 1'b0, 1'b1, 32'h0000_F0F0, 32'd0, 32'h0000_0F0F, 3'b011, 32'h0000_0F0F, 1'b0, 32'd0, 1'b1};
    vecs[10] = '{3'd3, 1'b0, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 3'b111, 32'hFFFF_FFFF, 1'b0, 32'd1, 1'b0};
    vecs[11] = '{3'd5, 1'b1, 1'b1, 32'hF000_0000, 32'd0, 32'h0000_0404, 3'b000, 32'd0, 1'b1, 32'd0, 1'b0};

    // Reset values while reset is held
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst alu_opcode", 32'(alu_opcode), 32'd0);
    chk("rst alu_a", alu_a, 32'd0);
    chk("rst alu_b", alu_b, 32'd0);
    chk("rst out_rd", 32'(out_rd), 32'd0);
    chk("rst out_result", out_result, 32'd0);
    chk("rst out_zero", 32'(out_zero), 32'd0);
    chk("rst out_illegal", 32'(out_illegal), 32'd0);
    chk_stats("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i], 5'(i + 1), i % 3, $sformatf("vec%0d", i));
    end

    // Backpressure: out_* stable, new requests ignored while DONE
    drive_in(vecs[0], 5'd3);
    @(posedge clk); #1;
    exp_issued++;
    scramble_in();
    @(posedge clk); #1;
    chk("bp out_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      drive_in(vecs[7], 5'd9);
      @(posedge clk); #1;
      chk($sformatf("bp%0d out_result", i), out_result, 32'd12);
      chk($sformatf("bp%0d out_rd", i), 32'(out_rd), 32'd3);
      chk($sformatf("bp%0d in_ready", i), 32'(in_ready), 32'd0);
      chk($sformatf("bp%0d out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d alu_a", i), alu_a, 32'd5);
    end
    // in_valid together with out_ready in DONE: only the handshake happens
    drive_in(vecs[1], 5'd4);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("both out_valid", 32'(out_valid), 32'd0);
    chk("both in_ready", 32'(in_ready), 32'd1);
    chk("both alu_a", alu_a, 32'd5);
    chk_stats("both");
    do_op(vecs[1], 5'd4, 0, "after_both");

    // Reset asserted while in EXEC
    drive_in(vecs[0], 5'd7);
    @(posedge clk); #1;
    scramble_in();
    chk("exec out_valid", 32'(out_valid), 32'd0);
    chk("exec in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    exp_issued  = 0;
    exp_illegal = 0;
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    chk("midrst out_result", out_result, 32'd0);
    chk("midrst alu_a", alu_a, 32'd0);
    chk_stats("midrst");
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst out_valid", 32'(out_valid), 32'd0);
    chk("postrst in_ready", 32'(in_ready), 32'd1);
    chk("postrst out_result", out_result, 32'd0);

    // Randomized ops against the reference model
    for (int i = 0; i < 60; i++) begin
      logic [31:0] r;
      r = $urandom;
      v = ref_model(3'(r[2:0]), r[3], r[4], $urandom,
                    r[5] ? 32'($urandom_range(0, 70)) : $urandom,
                    r[6] ? 32'($urandom_range(0, 70)) : $urandom);
      do_op(v, 5'($urandom), int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
      if (r[7]) begin
        @(posedge clk); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the bench always ends
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

endmodule
